// File: rtl/gpu_ctrl_pkg.sv
// Shared GPU command encodings and sequencer state type for the layer-header
// control path.
package gpu_ctrl_pkg;

  localparam logic [4:0] OP_RST_ALL_MEM = 5'b11000;
  localparam logic [4:0] OP_RST_LAYER   = 5'b11001;
  localparam logic [4:0] OP_WR_LAYER    = 5'b10001;

  localparam int unsigned OPCODE_MSB   = 15;
  localparam int unsigned OPCODE_LSB   = 11;
  localparam int unsigned IDX_LSB      = 6;
  localparam int unsigned ALL_FLAG_BIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLR_ALL = 2'd1,
    ST_CLR_ONE = 2'd2,
    ST_WR_DATA = 2'd3
  } seqState_t;

  // Index width for a counter over n items, never narrower than one bit.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_cmd_decode.sv
// Combinational GPU layer-command decoder: classifies the opcode and extracts
// the layer index with an out-of-range flag.
module layer_cmd_decode #(
  parameter int NUM_LAYERS  = 8,
  parameter int LAYER_IDX_W = $clog2(NUM_LAYERS)
) (
  input  logic [15:0]            cmd,
  output logic                   is_clr_all,
  output logic                   is_clr_one,
  output logic                   is_wr,
  output logic [LAYER_IDX_W-1:0] idx,
  output logic                   idx_bad
);
  import gpu_ctrl_pkg::*;

  logic [4:0] opcode;
  logic       allFlag;
  logic       unusedCmd;

  assign opcode  = cmd[OPCODE_MSB:OPCODE_LSB];
  assign allFlag = cmd[ALL_FLAG_BIT];
  assign idx     = cmd[IDX_LSB +: LAYER_IDX_W];
  assign idx_bad = 32'(idx) >= 32'(NUM_LAYERS);

  assign is_clr_all = (opcode == OP_RST_ALL_MEM) || ((opcode == OP_RST_LAYER) && allFlag);
  assign is_clr_one = (opcode == OP_RST_LAYER) && !allFlag;
  assign is_wr      = (opcode == OP_WR_LAYER);

  assign unusedCmd = ^cmd;

endmodule

// File: rtl/layer_header_seq.sv
// Layer-header command sequencer: runs clear sweeps and multi-word header
// writes against header storage and tracks which layers hold a complete header.
module layer_header_seq #(
  parameter int  NUM_LAYERS   = 8,
  parameter int  LAYER_IDX_W  = $clog2(NUM_LAYERS),
  parameter int  HEADER_WORDS = 4,
  parameter int  DATA_W       = 16,
  localparam int WORD_W       = (HEADER_WORDS > 1) ? $clog2(HEADER_WORDS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            cmd,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DATA_W-1:0]      data,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   hdr_we,
  output logic                   hdr_clr,
  output logic [LAYER_IDX_W-1:0] hdr_layer,
  output logic [WORD_W-1:0]      hdr_word,
  output logic [DATA_W-1:0]      hdr_wdata,
  output logic [NUM_LAYERS-1:0]  layer_valid,
  output logic                   busy,
  output logic                   err
);
  import gpu_ctrl_pkg::*;

  seqState_t              state;
  logic [LAYER_IDX_W-1:0] idxQ;
  logic [LAYER_IDX_W-1:0] sweepCnt;
  logic [WORD_W-1:0]      wordCnt;
  logic [NUM_LAYERS-1:0]  layerValidQ;
  logic                   errQ;

  logic                   isClrAll;
  logic                   isClrOne;
  logic                   isWr;
  logic [LAYER_IDX_W-1:0] decIdx;
  logic                   decIdxBad;

  logic accept;
  logic beat;
  logic lastBeat;
  logic lastSweep;

  layer_cmd_decode #(
    .NUM_LAYERS  (NUM_LAYERS),
    .LAYER_IDX_W (LAYER_IDX_W)
  ) uDecode (
    .cmd        (cmd),
    .is_clr_all (isClrAll),
    .is_clr_one (isClrOne),
    .is_wr      (isWr),
    .idx        (decIdx),
    .idx_bad    (decIdxBad)
  );

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = !cmd_ready;
  assign accept     = cmd_valid && cmd_ready;
  assign data_ready = (state == ST_WR_DATA);
  assign beat       = data_ready && data_valid;
  assign lastBeat   = 32'(wordCnt) == 32'(HEADER_WORDS - 1);
  assign lastSweep  = 32'(sweepCnt) == 32'(NUM_LAYERS - 1);

  assign hdr_we      = beat;
  assign hdr_clr     = (state == ST_CLR_ALL) || (state == ST_CLR_ONE);
  assign layer_valid = layerValidQ;
  assign err         = errQ;

  // Storage-side address/data are held at zero unless a strobe is active.
  always_comb begin
    hdr_layer = '0;
    hdr_word  = '0;
    hdr_wdata = '0;
    case (state)
      ST_CLR_ALL: hdr_layer = sweepCnt;
      ST_CLR_ONE: hdr_layer = idxQ;
      ST_WR_DATA: begin
        if (beat) begin
          hdr_layer = idxQ;
          hdr_word  = wordCnt;
          hdr_wdata = data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idxQ        <= '0;
      sweepCnt    <= '0;
      wordCnt     <= '0;
      layerValidQ <= '0;
      errQ        <= 1'b0;
    end else begin
      errQ <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (isClrAll) begin
              sweepCnt <= '0;
              state    <= ST_CLR_ALL;
            end else if (isClrOne || isWr) begin
              if (decIdxBad) begin
                errQ <= 1'b1;
              end else begin
                idxQ    <= decIdx;
                wordCnt <= '0;
                state   <= isWr ? ST_WR_DATA : ST_CLR_ONE;
              end
            end
          end
        end
        ST_CLR_ALL: begin
          layerValidQ[sweepCnt] <= 1'b0;
          if (lastSweep) begin
            sweepCnt <= '0;
            state    <= ST_IDLE;
          end else begin
            sweepCnt <= sweepCnt + 1'b1;
          end
        end
        ST_CLR_ONE: begin
          layerValidQ[idxQ] <= 1'b0;
          state             <= ST_IDLE;
        end
        ST_WR_DATA: begin
          if (beat) begin
            // First beat invalidates; a single-word header re-validates on the same edge.
            if (wordCnt == '0) layerValidQ[idxQ] <= 1'b0;
            if (lastBeat) begin
              layerValidQ[idxQ] <= 1'b1;
              wordCnt           <= '0;
              state             <= ST_IDLE;
            end else begin
              wordCnt <= wordCnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_header_seq.sv
// Self-checking bench for layer_header_seq: an 8-layer instance for the main
// scenarios plus a 6-layer instance for out-of-range index handling.
module tb_layer_header_seq;

  localparam int NL  = 8;
  localparam int HW  = 4;
  localparam int DW  = 16;
  localparam int IW  = 3;
  localparam int WW  = 2;
  localparam int NLS = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0]   cmd;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] data;
  logic          data_valid, data_ready;
  logic          hdr_we, hdr_clr;
  logic [IW-1:0] hdr_layer;
  logic [WW-1:0] hdr_word;
  logic [DW-1:0] hdr_wdata;
  logic [NL-1:0] layer_valid;
  logic          busy, err;

  logic [15:0]    sCmd;
  logic           sCmdValid, sCmdReady;
  logic [DW-1:0]  sData;
  logic           sDataValid, sDataReady;
  logic           sWe, sClr;
  logic [2:0]     sLayer;
  logic [WW-1:0]  sWord;
  logic [DW-1:0]  sWdata;
  logic [NLS-1:0] sLayerValid;
  logic           sBusy, sErr;

  layer_header_seq #(.NUM_LAYERS(NL), .HEADER_WORDS(HW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .hdr_we(hdr_we), .hdr_clr(hdr_clr), .hdr_layer(hdr_layer), .hdr_word(hdr_word),
    .hdr_wdata(hdr_wdata), .layer_valid(layer_valid), .busy(busy), .err(err)
  );

  layer_header_seq #(.NUM_LAYERS(NLS), .HEADER_WORDS(HW), .DATA_W(DW)) dutSmall (
    .clk(clk), .rst(rst), .cmd(sCmd), .cmd_valid(sCmdValid), .cmd_ready(sCmdReady),
    .data(sData), .data_valid(sDataValid), .data_ready(sDataReady),
    .hdr_we(sWe), .hdr_clr(sClr), .hdr_layer(sLayer), .hdr_word(sWord),
    .hdr_wdata(sWdata), .layer_valid(sLayerValid), .busy(sBusy), .err(sErr)
  );

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  int weCount = 0, clrCount = 0, errCount = 0;
  logic [NL-1:0] expVal;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (hdr_we === 1'b1) weCount++;
    if (hdr_clr === 1'b1) clrCount++;
    if (err === 1'b1) errCount++;
  end

  function automatic logic [15:0] wr_cmd(input int idx);
    return 16'h8800 | 16'(idx << 6);
  endfunction

  function automatic logic [15:0] clr_one_cmd(input int idx);
    return 16'hC800 | 16'(idx << 6);
  endfunction

  // Present a command on the main instance until it is taken; returns the accept cycle.
  task automatic issue_cmd(input logic [15:0] c, output int t);
    int waitCnt;
    waitCnt = 0;
    t = -1;
    cmd = c;
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        t = cyc;
        break;
      end
      waitCnt++;
      if (waitCnt > 100) begin
        nTests++; nFail++;
        $display("FAIL cmd_accept_timeout cmd=%h got cmd_ready=%b required 1", c, cmd_ready);
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input int idx, input logic [HW*DW-1:0] words, input logic [HW*4-1:0] gaps);
    int t;
    logic [NL-1:0] bitm;
    bitm = NL'(1) << idx;
    issue_cmd(wr_cmd(idx), t);
    for (int k = 0; k < HW; k++) begin
      for (int g = 0; g < int'(gaps[k*4 +: 4]); g++) begin
        data_valid = 1'b0;
        data = 16'($urandom);
        @(negedge clk);
        nTests++;
        if (hdr_we !== 1'b0 || data_ready !== 1'b1) begin
          nFail++;
          $display("FAIL wr_gap idx=%0d k=%0d got we=%b ready=%b required we=0 ready=1", idx, k, hdr_we, data_ready);
        end
        @(posedge clk); #1;
      end
      data_valid = 1'b1;
      data = words[k*DW +: DW];
      @(negedge clk);
      nTests++;
      if ({hdr_we, data_ready, hdr_layer, hdr_word, hdr_wdata} !==
          {1'b1, 1'b1, IW'(idx), WW'(k), words[k*DW +: DW]}) begin
        nFail++;
        $display("FAIL wr_beat idx=%0d k=%0d got we=%b ready=%b layer=%0d word=%0d wdata=%h required we=1 ready=1 layer=%0d word=%0d wdata=%h",
                 idx, k, hdr_we, data_ready, hdr_layer, hdr_word, hdr_wdata, idx, k, words[k*DW +: DW]);
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
      if (k == 0) begin
        nTests++;
        if (layer_valid !== (expVal & ~bitm)) begin
          nFail++;
          $display("FAIL wr_partial_invalid idx=%0d got valid=%h required %h", idx, layer_valid, expVal & ~bitm);
        end
      end
    end
    expVal |= bitm;
    @(negedge clk);
    nTests++;
    if ({cmd_ready, data_ready, hdr_we, layer_valid} !== {1'b1, 1'b0, 1'b0, expVal}) begin
      nFail++;
      $display("FAIL wr_done idx=%0d got ready=%b dready=%b we=%b valid=%h required ready=1 dready=0 we=0 valid=%h",
               idx, cmd_ready, data_ready, hdr_we, layer_valid, expVal);
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_layers(input int count);
    for (int i = 0; i < count; i++)
      do_write(i, {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)}, '0);
  endtask

  task automatic run_clear_all(input logic [15:0] c, input bit hold);
    int t, clrBefore;
    logic [NL-1:0] exp;
    clrBefore = clrCount;
    issue_cmd(c, t);
    if (hold) cmd_valid = 1'b1;
    for (int i = 0; i < NL; i++) begin
      @(negedge clk);
      exp = expVal & ~((NL'(1) << i) - NL'(1));
      nTests++;
      if ({hdr_clr, hdr_we, hdr_layer, busy, cmd_ready, layer_valid} !==
          {1'b1, 1'b0, IW'(i), 1'b1, 1'b0, exp}) begin
        nFail++;
        $display("FAIL clr_all_step cmd=%h i=%0d got clr=%b we=%b layer=%0d busy=%b ready=%b valid=%h required clr=1 we=0 layer=%0d busy=1 ready=0 valid=%h",
                 c, i, hdr_clr, hdr_we, hdr_layer, busy, cmd_ready, layer_valid, i, exp);
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    expVal = '0;
    @(negedge clk);
    nTests++;
    if ({cmd_ready, hdr_clr, layer_valid} !== {1'b1, 1'b0, expVal}) begin
      nFail++;
      $display("FAIL clr_all_done cmd=%h got ready=%b clr=%b valid=%h required ready=1 clr=0 valid=00",
               c, cmd_ready, hdr_clr, layer_valid);
    end
    @(negedge clk);
    nTests++;
    if ({cmd_ready, hdr_clr} !== 2'b10) begin
      nFail++;
      $display("FAIL clr_all_no_repeat cmd=%h got ready=%b clr=%b required ready=1 clr=0", c, cmd_ready, hdr_clr);
    end
    @(posedge clk); #1;
    nTests++;
    if (clrCount - clrBefore != NL) begin
      nFail++;
      $display("FAIL clr_all_count cmd=%h got %0d clears required %0d", c, clrCount - clrBefore, NL);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd = '0; cmd_valid = 1'b0; data = '0; data_valid = 1'b0;
    sCmd = '0; sCmdValid = 1'b0; sData = '0; sDataValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    expVal = '0;
    weCount = 0; clrCount = 0; errCount = 0;
    @(negedge clk);
    nTests++;
    if ({cmd_ready, busy, data_ready, hdr_we, hdr_clr, hdr_layer, hdr_word, hdr_wdata, layer_valid, err} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IW'(0), WW'(0), DW'(0), NL'(0), 1'b0}) begin
      nFail++;
      $display("FAIL reset_state got ready=%b busy=%b dready=%b we=%b clr=%b layer=%0d word=%0d wdata=%h valid=%h err=%b required ready=1 others 0",
               cmd_ready, busy, data_ready, hdr_we, hdr_clr, hdr_layer, hdr_word, hdr_wdata, layer_valid, err);
    end
    nTests++;
    if ({sCmdReady, sBusy, sLayerValid, sErr} !== {1'b1, 1'b0, NLS'(0), 1'b0}) begin
      nFail++;
      $display("FAIL reset_small got ready=%b busy=%b valid=%h err=%b required ready=1 busy=0 valid=00 err=0",
               sCmdReady, sBusy, sLayerValid, sErr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_basic;
    do_write(2, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 16'h0100);
    nTests++;
    if (layer_valid !== 8'h04) begin
      nFail++;
      $display("FAIL wr_basic_valid got %h required 04", layer_valid);
    end
  endtask

  task automatic test_write_random;
    for (int n = 0; n < 6; n++)
      do_write(int'($urandom_range(0, NL - 1)),
               {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)},
               {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))});
  endtask

  task automatic test_clear_all;
    fill_layers(NL);
    nTests++;
    if (layer_valid !== 8'hFF) begin
      nFail++;
      $display("FAIL fill_all got %h required ff", layer_valid);
    end
    run_clear_all(16'hC000, 1'b0);
    fill_layers(NL);
    run_clear_all(16'hC820, 1'b1);
  endtask

  task automatic test_clear_one;
    int t;
    fill_layers(4);
    issue_cmd(clr_one_cmd(1), t);
    @(negedge clk);
    nTests++;
    if ({hdr_clr, hdr_we, hdr_layer, busy} !== {1'b1, 1'b0, IW'(1), 1'b1}) begin
      nFail++;
      $display("FAIL clr_one_strobe got clr=%b we=%b layer=%0d busy=%b required clr=1 we=0 layer=1 busy=1",
               hdr_clr, hdr_we, hdr_layer, busy);
    end
    expVal &= ~NL'(2);
    @(negedge clk);
    nTests++;
    if ({cmd_ready, hdr_clr, layer_valid} !== {1'b1, 1'b0, 8'h0D}) begin
      nFail++;
      $display("FAIL clr_one_done got ready=%b clr=%b valid=%h required ready=1 clr=0 valid=0d",
               cmd_ready, hdr_clr, layer_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore;
    int t, we0;
    logic [4:0] op;
    logic [15:0] c;
    we0 = weCount;
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = 16'($urandom);
      @(negedge clk);
      nTests++;
      if ({hdr_we, data_ready, cmd_ready} !== 3'b001) begin
        nFail++;
        $display("FAIL idle_data got we=%b dready=%b ready=%b required we=0 dready=0 ready=1", hdr_we, data_ready, cmd_ready);
      end
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (n == 0) begin
        c = 16'h0000;
      end else begin
        do op = 5'($urandom); while (op == 5'b11000 || op == 5'b11001 || op == 5'b10001);
        c = {op, 11'($urandom)};
      end
      issue_cmd(c, t);
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        nTests++;
        if ({cmd_ready, busy, hdr_we, hdr_clr, err, data_ready, layer_valid} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, expVal}) begin
          nFail++;
          $display("FAIL unknown_op cmd=%h got ready=%b busy=%b we=%b clr=%b err=%b dready=%b valid=%h required ready=1 others 0 valid=%h",
                   c, cmd_ready, busy, hdr_we, hdr_clr, err, data_ready, layer_valid, expVal);
        end
        @(posedge clk); #1;
      end
    end
    nTests++;
    if (weCount != we0) begin
      nFail++;
      $display("FAIL ignore_we_count got %0d writes required 0", weCount - we0);
    end
  endtask

  task automatic test_bad_index;
    logic [15:0] badCmds [2];
    badCmds[0] = 16'h89C0;
    badCmds[1] = 16'hC980;
    sCmd = 16'h8940;
    sCmdValid = 1'b1;
    @(negedge clk);
    nTests++;
    if (sCmdReady !== 1'b1) begin
      nFail++;
      $display("FAIL small_wr_accept got ready=%b required 1", sCmdReady);
    end
    @(posedge clk); #1;
    sCmdValid = 1'b0;
    sDataValid = 1'b1;
    for (int k = 0; k < HW; k++) begin
      sData = 16'($urandom);
      @(negedge clk);
      nTests++;
      if ({sWe, sLayer, sWord, sWdata} !== {1'b1, 3'd5, WW'(k), sData}) begin
        nFail++;
        $display("FAIL small_wr_beat k=%0d got we=%b layer=%0d word=%0d wdata=%h required we=1 layer=5 word=%0d wdata=%h",
                 k, sWe, sLayer, sWord, sWdata, k, sData);
      end
      @(posedge clk); #1;
    end
    for (int n = 0; n < 2; n++) begin
      sCmd = badCmds[n];
      sCmdValid = 1'b1;
      sDataValid = 1'b1;
      @(negedge clk);
      nTests++;
      if ({sCmdReady, sErr} !== 2'b10) begin
        nFail++;
        $display("FAIL bad_idx_accept cmd=%h got ready=%b err=%b required ready=1 err=0", sCmd, sCmdReady, sErr);
      end
      @(posedge clk); #1;
      sCmdValid = 1'b0;
      @(negedge clk);
      nTests++;
      if ({sErr, sCmdReady, sBusy, sDataReady, sWe, sClr, sLayerValid} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h20}) begin
        nFail++;
        $display("FAIL bad_idx_t1 cmd=%h got err=%b ready=%b busy=%b dready=%b we=%b clr=%b valid=%h required err=1 ready=1 busy=0 dready=0 we=0 clr=0 valid=20",
                 sCmd, sErr, sCmdReady, sBusy, sDataReady, sWe, sClr, sLayerValid);
      end
      @(negedge clk);
      nTests++;
      if ({sErr, sWe, sClr, sDataReady, sLayerValid} !== {4'b0000, 6'h20}) begin
        nFail++;
        $display("FAIL bad_idx_t2 cmd=%h got err=%b we=%b clr=%b dready=%b valid=%h required all 0 valid=20",
                 sCmd, sErr, sWe, sClr, sDataReady, sLayerValid);
      end
      @(posedge clk); #1;
      sDataValid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_op;
    int t;
    issue_cmd(wr_cmd(5), t);
    data_valid = 1'b1;
    data = 16'h1111;
    @(posedge clk); #1;
    data = 16'h2222;
    @(posedge clk); #1;
    data_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expVal = '0;
    @(negedge clk);
    nTests++;
    if ({cmd_ready, busy, data_ready, hdr_we, hdr_word, layer_valid, err} !==
        {1'b1, 1'b0, 1'b0, 1'b0, WW'(0), NL'(0), 1'b0}) begin
      nFail++;
      $display("FAIL rst_mid_write got ready=%b busy=%b dready=%b we=%b word=%0d valid=%h err=%b required ready=1 others 0",
               cmd_ready, busy, data_ready, hdr_we, hdr_word, layer_valid, err);
    end
    @(posedge clk); #1;
    do_write(5, {16'hD3, 16'hD2, 16'hD1, 16'hD0}, '0);
    issue_cmd(16'hC000, t);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expVal = '0;
    @(negedge clk);
    nTests++;
    if ({cmd_ready, busy, hdr_clr, hdr_layer, layer_valid} !== {1'b1, 1'b0, 1'b0, IW'(0), NL'(0)}) begin
      nFail++;
      $display("FAIL rst_mid_sweep got ready=%b busy=%b clr=%b layer=%0d valid=%h required ready=1 busy=0 clr=0 layer=0 valid=00",
               cmd_ready, busy, hdr_clr, hdr_layer, layer_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_write_basic;
    test_write_random;
    test_clear_all;
    test_clear_one;
    test_ignore;
    test_bad_index;
    test_reset_mid_op;
    nTests++;
    if (errCount != 0) begin
      nFail++;
      $display("FAIL main_err_pulses got %0d required 0", errCount);
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/layer_header_seq.md
Name: layer_header_seq

Overview:
Parametrised command sequencer for the GPU layer-header register file. Decodes 16-bit GPU commands (reset-all-memories, reset-all-headers, reset-one-header, write-header). Executes them as multi-cycle operations: sweeps clears one layer per cycle and streams multi-word header writes over a valid/ready data port. Tracks a per-layer "header valid" bitmap and sits between the GPU command FIFO and the layer-header storage.

Parameters:
NUM_LAYERS, 8, number of layer headers; 2..32
LAYER_IDX_W, $clog2(NUM_LAYERS), layer index width; max 5, taken from cmd[6+LAYER_IDX_W-1:6]
HEADER_WORDS, 4, data words per header write; 1..16
DATA_W, 16, header data word width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd  in  16  GPU command word
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer idle and accepting
data  in  DATA_W  header data word
data_valid  in  1  data word present
data_ready  out  1  sequencer consuming header words
hdr_we  out  1  write strobe to header storage
hdr_clr  out  1  clear strobe for layer hdr_layer (all words)
hdr_layer  out  LAYER_IDX_W  target layer of hdr_we/hdr_clr
hdr_word  out  $clog2(HEADER_WORDS) (min 1)  word index of hdr_we
hdr_wdata  out  DATA_W  write data
layer_valid  out  NUM_LAYERS  bit i = layer i holds a complete header
busy  out  1  not IDLE
err  out  1  one-cycle pulse: accepted command had index >= NUM_LAYERS

Behaviour:
- Decode on cmd[15:11]: 11000 = reset all memories -> clear all; 11001 with cmd[5]=1 = clear all; 11001 with cmd[5]=0 = clear one; 10001 = write header. Any other opcode is accepted and ignored: no output activity, stay IDLE.
- Accept = cmd_valid & cmd_ready in cycle T. cmd_ready = (state==IDLE). busy = !cmd_ready.
- States: IDLE, CLR_ALL, CLR_ONE, WR_DATA.
- CLR_ALL: cycles T+1..T+NUM_LAYERS, hdr_clr=1, hdr_layer=0,1,..,NUM_LAYERS-1. layer_valid bit cleared on each clear edge. IDLE at T+NUM_LAYERS+1.
- CLR_ONE: index idx=cmd index field latched at T. T+1: hdr_clr=1, hdr_layer=idx, layer_valid[idx] cleared on that edge. IDLE at T+2.
- WR_DATA: idx latched and word counter=0 at T. data_ready=1 throughout. For each beat with data_valid high: hdr_we=1, hdr_layer=idx, hdr_word=counter, hdr_wdata=data, all combinational same cycle; counter increments. On beat HEADER_WORDS-1: layer_valid[idx] set on that edge, state->IDLE. No timeout; data_valid gaps simply stall.
- layer_valid[idx] is cleared at the first accepted beat of a write, so a partially written header never reads valid.
- Bad index (idx >= NUM_LAYERS) on clear-one or write: command accepted, err=1 at T+1, no clr/we, stays IDLE, no data consumed.
- Outside their states, hdr_we/hdr_clr/data_ready = 0; data_valid is ignored.
- cmd_valid while busy: not accepted; the command must be held by the source.
- rst, at any time including mid-sweep or mid-write: state=IDLE, counters=0, layer_valid=0, err=0. After reset, all strobes=0, hdr_layer/hdr_word/hdr_wdata=0, cmd_ready=1 from the first cycle after reset deasserts.

Decomposition:
- Package gpu_ctrl_pkg: opcode constants OP_RST_ALL_MEM=5'b11000, OP_RST_LAYER=5'b11001, OP_WR_LAYER=5'b10001; field positions (opcode [15:11], index lsb 6, all-flag bit 5); state enum.
- One combinational sub-module, layer_cmd_decode: cmd -> {is_clr_all, is_clr_one, is_wr, idx, idx_bad}. Reusable by other GPU controllers.

Test Plan:
- Reset then write: cmd=0x8880 (wr, idx 2), 4 beats 0xA0..0xA3 with one idle gap -> 4 hdr_we, hdr_layer=2, hdr_word 0..3, layer_valid=0x04 after beat 3, cmd_ready at next cycle.
- Clear all: with layer_valid=0xFF, cmd=0xC000 -> hdr_clr for 8 cycles, layers 0..7, layer_valid=0x00, IDLE at T+9. Repeat with cmd=0xC820 -> same result.
- Clear one: layer_valid=0x0F, cmd=0xC840 (idx 1, bit5=0) -> single hdr_clr at T+1, layer 1, layer_valid=0x0D.
- Bad index: NUM_LAYERS=6, cmd=0x89C0 (idx 7) -> err pulse T+1, no we/clr, data_ready stays 0, layer_valid unchanged.
- Backpressure/ignore: cmd_valid held during CLR_ALL -> accepted only once, at IDLE. data_valid in IDLE -> no hdr_we. Unknown opcode 0x0000 -> no activity.
- Reset mid-write after 2 beats -> IDLE, layer_valid=0, next write restarts at hdr_word=0.
